// File: rtl/dmem_bus_ctrl_if.sv
// Bundle of MEM-stage request, pipeline status and external data-bus signals
// for the data-memory bus sequencer. The controller owns the master side.
interface dmem_bus_ctrl_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] DAD;
    logic [31:0] ddt_out;
    logic        ddt_oe;
    logic [31:0] ddt_in;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;
    logic [1:0]  dbg_state;

    modport master (
        input  req_read, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  ddt_in, ACKD_n,
        output stall, done, err, rdata,
        output DAD, ddt_out, ddt_oe, MREQ, WRITE, SIZE, dbg_state
    );

    modport slave (
        output req_read, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output ddt_in, ACKD_n,
        input  stall, done, err, rdata,
        input  DAD, ddt_out, ddt_oe, MREQ, WRITE, SIZE, dbg_state
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus sequencer: one load/store request becomes one handshaked
// bus transaction, with lane steering, load extension and ack timeout.
module dmem_bus_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic           clk,
    input logic           rst,
    dmem_bus_ctrl_if.master bus
);
    // Handshake: a request (req_read|req_write) is taken in IDLE when aligned;
    // the bus cycle runs while MREQ=1 and completes on the clock edge that
    // samples ACKD_n=0. stall holds the pipeline until the DONE/ABORT cycle.
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ABORT} state_t;

    state_t            state_q, state_d;
    logic              req, mis, accept, ack, timeout;
    logic [31:0]       addr_q, ddt_out_q, rdata_q, steer, load_ext;
    logic [1:0]        size_q;
    logic              dir_q, uns_q, mis_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign req     = bus.req_read | bus.req_write;
    assign ack     = ~bus.ACKD_n;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign accept  = (state_q == IDLE) && req && !mis;

    always_comb begin
        mis = 1'b0;
        case (bus.req_size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = bus.req_addr[0];
            2'b10:   mis = (bus.req_addr[1:0] != 2'b00);
            default: mis = 1'b1;
        endcase
    end

    always_comb begin
        steer = bus.req_wdata;
        case (bus.req_size)
            2'b00:   steer = {4{bus.req_wdata[7:0]}};
            2'b01:   steer = {2{bus.req_wdata[15:0]}};
            default: steer = bus.req_wdata;
        endcase
    end

    // Lane selection uses the latched address, not the live request.
    assign lane_b = bus.ddt_in[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = bus.ddt_in[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = bus.ddt_in;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = bus.ddt_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  begin
                // An ack on the final allowed cycle still completes normally.
                if (ack)          state_d = DONE;
                else if (timeout) state_d = ABORT;
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= '0;
            dir_q     <= 1'b0;
            uns_q     <= 1'b0;
            ddt_out_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            mis_err_q <= 1'b0;
        end else begin
            mis_err_q <= (state_q == IDLE) && req && mis;
            if (accept) begin
                addr_q    <= bus.req_addr;
                size_q    <= bus.req_size;
                dir_q     <= ~bus.req_read;
                uns_q     <= bus.req_unsigned;
                ddt_out_q <= steer;
                cnt_q     <= '0;
            end
            if (state_q == ACCESS) begin
                if (!ack)          cnt_q   <= cnt_q + CNT_W'(1);
                if (ack && !dir_q) rdata_q <= load_ext;
            end
        end
    end

    assign bus.MREQ      = (state_q == ACCESS);
    assign bus.WRITE     = (state_q == ACCESS) && dir_q;
    assign bus.ddt_oe    = (state_q == ACCESS) && dir_q;
    assign bus.done      = (state_q == DONE);
    assign bus.err       = mis_err_q || (state_q == ABORT);
    assign bus.stall     = accept || (state_q == ACCESS);
    assign bus.DAD       = {addr_q[31:2], 2'b00};
    assign bus.SIZE      = size_q;
    assign bus.ddt_out   = ddt_out_q;
    assign bus.rdata     = rdata_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: latency, lane steering, extension,
// misalignment, timeout, mid-access reset and back-to-back spacing.
module tb_dmem_bus_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [31:0] last_rdata = 32'h0;

    dmem_bus_ctrl_if bus ();

    dmem_bus_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        bus.req_read     = rd;
        bus.req_write    = wr;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
    endtask

    task automatic clr_req();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        clr_req();
        bus.ACKD_n = 1'b1;
        bus.ddt_in = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.MREQ, bus.WRITE, bus.ddt_oe, bus.done, bus.err, bus.stall} !== 6'b0) begin
            $display("FAIL reset_ctrl got %b exp 000000",
                     {bus.MREQ, bus.WRITE, bus.ddt_oe, bus.done, bus.err, bus.stall});
            n_miss++;
        end
        n_vec++;
        if ({bus.DAD, bus.ddt_out, bus.rdata, bus.SIZE} !== 98'h0) begin
            $display("FAIL reset_data got DAD=%h ddt_out=%h rdata=%h SIZE=%b exp all 0",
                     bus.DAD, bus.ddt_out, bus.rdata, bus.SIZE);
            n_miss++;
        end
        // A stray ack outside ACCESS must not produce any activity.
        bus.ACKD_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({bus.MREQ, bus.done, bus.err} !== 3'b0) begin
            $display("FAIL stray_ack got MREQ/done/err=%b exp 000", {bus.MREQ, bus.done, bus.err});
            n_miss++;
        end
        bus.ACKD_n = 1'b1;
    endtask

    task automatic test_word_load();
        set_req(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        #1;
        n_vec++;
        if ({bus.stall, bus.MREQ} !== 2'b10) begin
            $display("FAIL wl_cycle0 got stall/MREQ=%b exp 10", {bus.stall, bus.MREQ});
            n_miss++;
        end
        tick();
        n_vec++;
        if ({bus.stall, bus.MREQ, bus.WRITE, bus.ddt_oe} !== 4'b1100 || bus.DAD !== 32'h100
            || bus.SIZE !== 2'b10) begin
            $display("FAIL wl_cycle1 got stall/MREQ/WRITE/oe=%b DAD=%h SIZE=%b exp 1100 00000100 10",
                     {bus.stall, bus.MREQ, bus.WRITE, bus.ddt_oe}, bus.DAD, bus.SIZE);
            n_miss++;
        end
        bus.ddt_in = 32'hDEADBEEF;
        bus.ACKD_n = 1'b0;
        tick();
        n_vec++;
        if ({bus.done, bus.err, bus.MREQ, bus.stall} !== 4'b1000 || bus.rdata !== 32'hDEADBEEF) begin
            $display("FAIL wl_cycle2 got done/err/MREQ/stall=%b rdata=%h exp 1000 deadbeef",
                     {bus.done, bus.err, bus.MREQ, bus.stall}, bus.rdata);
            n_miss++;
        end
        last_rdata = 32'hDEADBEEF;
        clr_req();
        bus.ACKD_n = 1'b1;
        bus.ddt_in = 32'h0;
        tick();
        n_vec++;
        if ({bus.done, bus.MREQ} !== 2'b00 || bus.rdata !== 32'hDEADBEEF) begin
            $display("FAIL wl_cycle3 got done/MREQ=%b rdata=%h exp 00 deadbeef",
                     {bus.done, bus.MREQ}, bus.rdata);
            n_miss++;
        end
    endtask

    logic [31:0] le_addr [5] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h201};
    logic [1:0]  le_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        le_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] le_data [5] = '{32'h80112233, 32'h80112233, 32'h80011234, 32'h8001F234, 32'h80112233};
    logic [31:0] le_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F234, 32'h00000022};

    task automatic test_load_ext();
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b0, le_addr[i], 32'h0, le_size[i], le_uns[i]);
            tick();
            bus.ddt_in = le_data[i];
            bus.ACKD_n = 1'b0;
            tick();
            n_vec++;
            if (bus.done !== 1'b1 || bus.rdata !== le_exp[i]) begin
                $display("FAIL load_ext[%0d] got done=%b rdata=%h exp 1 %h",
                         i, bus.done, bus.rdata, le_exp[i]);
                n_miss++;
            end
            last_rdata = le_exp[i];
            clr_req();
            bus.ACKD_n = 1'b1;
            tick();
        end
    endtask

    task automatic test_store();
        int act = 0;
        int good = 0;
        int dn = 0;
        set_req(1'b0, 1'b1, 32'h45, 32'h000000A5, 2'b00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.MREQ) begin
                act++;
                if (bus.WRITE && bus.ddt_oe && bus.ddt_out === 32'hA5A5A5A5 && bus.DAD === 32'h44)
                    good++;
                bus.ACKD_n = (act < 4) ? 1'b1 : 1'b0;
            end else begin
                bus.ACKD_n = 1'b1;
            end
            if (bus.done) begin
                dn++;
                clr_req();
            end
        end
        clr_req();
        bus.ACKD_n = 1'b1;
        n_vec++;
        if (act != 4 || good != 4 || dn != 1) begin
            $display("FAIL byte_store got access=%0d good=%0d done=%0d exp 4 4 1", act, good, dn);
            n_miss++;
        end
        set_req(1'b0, 1'b1, 32'h46, 32'h0000BEEF, 2'b01, 1'b0);
        tick();
        n_vec++;
        if (bus.ddt_out !== 32'hBEEFBEEF || {bus.MREQ, bus.WRITE, bus.ddt_oe} !== 3'b111
            || bus.DAD !== 32'h44) begin
            $display("FAIL half_store got ddt_out=%h MREQ/WRITE/oe=%b DAD=%h exp beefbeef 111 00000044",
                     bus.ddt_out, {bus.MREQ, bus.WRITE, bus.ddt_oe}, bus.DAD);
            n_miss++;
        end
        bus.ACKD_n = 1'b0;
        tick();
        n_vec++;
        if (bus.done !== 1'b1 || bus.rdata !== last_rdata) begin
            $display("FAIL half_store_done got done=%b rdata=%h exp 1 %h", bus.done, bus.rdata, last_rdata);
            n_miss++;
        end
        clr_req();
        bus.ACKD_n = 1'b1;
        tick();
    endtask

    logic [31:0] ms_addr [3] = '{32'h102, 32'h100, 32'h201};
    logic [1:0]  ms_size [3] = '{2'b10, 2'b11, 2'b01};

    task automatic test_misaligned();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, ms_addr[i], 32'h0, ms_size[i], 1'b0);
            #1;
            n_vec++;
            if (bus.stall !== 1'b0) begin
                $display("FAIL mis_stall[%0d] got %b exp 0", i, bus.stall);
                n_miss++;
            end
            tick();
            n_vec++;
            if ({bus.err, bus.MREQ, bus.done} !== 3'b100) begin
                $display("FAIL mis_err[%0d] got err/MREQ/done=%b exp 100", i, {bus.err, bus.MREQ, bus.done});
                n_miss++;
            end
            clr_req();
            tick();
            n_vec++;
            if ({bus.err, bus.MREQ} !== 2'b00) begin
                $display("FAIL mis_after[%0d] got err/MREQ=%b exp 00", i, {bus.err, bus.MREQ});
                n_miss++;
            end
        end
    endtask

    task automatic test_timeout();
        int mcnt = 0;
        int errs = 0;
        int dn = 0;
        bus.ACKD_n = 1'b1;
        bus.ddt_in = 32'h5555AAAA;
        set_req(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.MREQ) mcnt++;
            if (bus.err)  begin errs++; clr_req(); end
            if (bus.done) begin dn++;   clr_req(); end
        end
        clr_req();
        n_vec++;
        if (mcnt != 16 || errs != 1 || dn != 0 || bus.rdata !== last_rdata) begin
            $display("FAIL timeout got mreq=%0d err=%0d done=%0d rdata=%h exp 16 1 0 %h",
                     mcnt, errs, dn, bus.rdata, last_rdata);
            n_miss++;
        end
        mcnt = 0; errs = 0; dn = 0;
        bus.ddt_in = 32'h12345678;
        set_req(1'b1, 1'b0, 32'h404, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.MREQ) begin
                mcnt++;
                bus.ACKD_n = (mcnt == 16) ? 1'b0 : 1'b1;
            end else begin
                bus.ACKD_n = 1'b1;
            end
            if (bus.err)  begin errs++; clr_req(); end
            if (bus.done) begin dn++;   clr_req(); end
        end
        clr_req();
        bus.ACKD_n = 1'b1;
        n_vec++;
        if (mcnt != 16 || errs != 0 || dn != 1 || bus.rdata !== 32'h12345678) begin
            $display("FAIL late_ack got mreq=%0d err=%0d done=%0d rdata=%h exp 16 0 1 12345678",
                     mcnt, errs, dn, bus.rdata);
            n_miss++;
        end
        last_rdata = 32'h12345678;
    endtask

    task automatic test_reset_mid();
        set_req(1'b1, 1'b0, 32'h500, 32'h0, 2'b10, 1'b0);
        tick();
        tick();
        n_vec++;
        if (bus.MREQ !== 1'b1) begin
            $display("FAIL rm_access2 got MREQ=%b exp 1", bus.MREQ);
            n_miss++;
        end
        rst = 1'b1;
        clr_req();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.MREQ, bus.stall, bus.done, bus.err} !== 4'b0 || bus.rdata !== 32'h0) begin
            $display("FAIL rm_reset got MREQ/stall/done/err=%b rdata=%h exp 0000 00000000",
                     {bus.MREQ, bus.stall, bus.done, bus.err}, bus.rdata);
            n_miss++;
        end
        tick();
        n_vec++;
        if ({bus.MREQ, bus.done, bus.err} !== 3'b0) begin
            $display("FAIL rm_quiet got MREQ/done/err=%b exp 000", {bus.MREQ, bus.done, bus.err});
            n_miss++;
        end
        set_req(1'b1, 1'b0, 32'h504, 32'h0, 2'b10, 1'b0);
        tick();
        bus.ddt_in = 32'hCAFEF00D;
        bus.ACKD_n = 1'b0;
        tick();
        n_vec++;
        if (bus.done !== 1'b1 || bus.rdata !== 32'hCAFEF00D || bus.err !== 1'b0) begin
            $display("FAIL rm_reload got done=%b err=%b rdata=%h exp 1 0 cafef00d",
                     bus.done, bus.err, bus.rdata);
            n_miss++;
        end
        last_rdata = 32'hCAFEF00D;
        clr_req();
        bus.ACKD_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] mpat = 8'h0;
        int dn = 0;
        // Request and ack held low throughout: each transaction takes 3 cycles.
        bus.ddt_in = 32'h0BADF00D;
        bus.ACKD_n = 1'b0;
        set_req(1'b1, 1'b0, 32'h600, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            mpat = {mpat[6:0], bus.MREQ};
            if (bus.done) dn++;
        end
        clr_req();
        bus.ACKD_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (mpat !== 8'b10010010 || dn != 3) begin
            $display("FAIL b2b got mreq_pattern=%b done=%0d exp 10010010 3", mpat, dn);
            n_miss++;
        end
        n_vec++;
        if (bus.rdata !== 32'h0BADF00D) begin
            $display("FAIL b2b_rdata got %h exp 0badf00d", bus.rdata);
            n_miss++;
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
